// File: rtl/icache_tag_lookup_ctrl_pkg.sv
// Shared types, geometry and address helpers for the instruction-cache tag controller.
package drac_icache_pkg;

    localparam int WAYS         = 4;
    localparam int TAG_WIDHT    = 20;
    localparam int ICACHE_DEPTH = 256;
    localparam int ADDR_WIDHT   = $clog2(ICACHE_DEPTH);
    localparam int OFFSET_WIDTH = 4;
    localparam int WAY_IDX_W    = $clog2(WAYS);
    localparam int PADDR_WIDTH  = TAG_WIDHT + ADDR_WIDHT + OFFSET_WIDTH;

    typedef logic [PADDR_WIDTH-1:0] paddr_t;
    typedef logic [TAG_WIDHT-1:0]   tag_t;
    typedef logic [ADDR_WIDHT-1:0]  index_t;
    typedef logic [WAY_IDX_W-1:0]   way_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        COMPARE,
        REFILL,
        FILL,
        RESP,
        FLUSH
    } state_e;

    function automatic tag_t addr_tag(input paddr_t a);
        return a[PADDR_WIDTH-1 -: TAG_WIDHT];
    endfunction

    function automatic index_t addr_index(input paddr_t a);
        return a[OFFSET_WIDTH +: ADDR_WIDHT];
    endfunction

    // Refills are whole lines, so the offset field is forced to zero.
    function automatic paddr_t line_addr(input paddr_t a);
        return a & ~paddr_t'((1 << OFFSET_WIDTH) - 1);
    endfunction

endpackage

// File: rtl/icache_tag_lookup_ctrl_if.sv
// Bundle of core fetch, flush, tag-memory and refill signals seen by the tag controller.
interface icache_tag_lookup_ctrl_if;
    import drac_icache_pkg::*;

    logic                        req_valid_i;
    logic                        req_ready_o;
    paddr_t                      req_addr_i;
    logic                        resp_valid_o;
    logic                        resp_hit_o;
    way_idx_t                    resp_way_o;
    logic                        flush_i;
    logic                        flush_done_o;
    logic [WAYS-1:0]             tag_req_o;
    logic [WAYS-1:0]             tag_we_o;
    index_t                      tag_addr_o;
    tag_t                        tag_data_o;
    logic                        tag_vbit_o;
    logic                        tag_flush_o;
    logic [WAYS*TAG_WIDHT-1:0]   tag_data_i;
    logic [WAYS-1:0]             tag_vbit_i;
    logic                        refill_req_o;
    paddr_t                      refill_addr_o;
    logic                        refill_done_i;

    modport master (
        input  req_valid_i, req_addr_i, flush_i, tag_data_i, tag_vbit_i, refill_done_i,
        output req_ready_o, resp_valid_o, resp_hit_o, resp_way_o, flush_done_o,
               tag_req_o, tag_we_o, tag_addr_o, tag_data_o, tag_vbit_o, tag_flush_o,
               refill_req_o, refill_addr_o
    );

    modport slave (
        output req_valid_i, req_addr_i, flush_i, tag_data_i, tag_vbit_i, refill_done_i,
        input  req_ready_o, resp_valid_o, resp_hit_o, resp_way_o, flush_done_o,
               tag_req_o, tag_we_o, tag_addr_o, tag_data_o, tag_vbit_o, tag_flush_o,
               refill_req_o, refill_addr_o
    );

endinterface

// File: rtl/icache_tag_lookup_ctrl_victim_sel.sv
// Victim choice for a miss: first invalid way, else the round-robin pointer.
module icache_victim_sel
    import drac_icache_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [WAYS-1:0] vbit_i,
    input  logic            advance_i,
    input  logic            clear_i,
    output way_idx_t        victim_o,
    output logic            from_ptr_o
);

    way_idx_t ptr_q, ptr_d;
    way_idx_t first_inv;
    logic     any_inv;

    // Scan from the top so the lowest-index invalid way wins.
    always_comb begin
        first_inv = '0;
        any_inv   = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!vbit_i[w]) begin
                first_inv = way_idx_t'(w);
                any_inv   = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (clear_i) begin
            ptr_d = '0;
        end else if (advance_i) begin
            ptr_d = ptr_q + way_idx_t'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign victim_o   = any_inv ? first_inv : ptr_q;
    assign from_ptr_o = !any_inv;

endmodule

// File: rtl/icache_tag_lookup_ctrl.sv
// Tag lookup / refill / invalidate sequencer driving the per-way tag and valid-bit memories.
module icache_tag_lookup_ctrl
    import drac_icache_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    icache_tag_lookup_ctrl_if.master  bus
);

    state_e   state_q, state_d;
    paddr_t   addr_q, addr_d;
    way_idx_t victim_q, victim_d;
    logic     from_ptr_q, from_ptr_d;
    logic     resp_hit_q, resp_hit_d;
    way_idx_t resp_way_q, resp_way_d;
    logic     flush_pending_q, flush_pending_d;
    logic     flush_done_q, flush_done_d;

    logic            hit_any;
    way_idx_t        hit_way;
    way_idx_t        victim;
    logic            victim_from_ptr;
    logic [WAYS-1:0] victim_onehot;

    icache_victim_sel u_victim_sel (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .vbit_i     (bus.tag_vbit_i),
        .advance_i  (state_q == FILL && from_ptr_q),
        .clear_i    (state_q == FLUSH),
        .victim_o   (victim),
        .from_ptr_o (victim_from_ptr)
    );

    // Read data is only meaningful in COMPARE; lowest-index matching way wins.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (bus.tag_vbit_i[w] &&
                bus.tag_data_i[w*TAG_WIDHT +: TAG_WIDHT] == addr_tag(addr_q)) begin
                hit_any = 1'b1;
                hit_way = way_idx_t'(w);
            end
        end
    end

    assign victim_onehot = {{(WAYS-1){1'b0}}, 1'b1} << victim_q;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        victim_d        = victim_q;
        from_ptr_d      = from_ptr_q;
        resp_hit_d      = resp_hit_q;
        resp_way_d      = resp_way_q;
        flush_done_d    = 1'b0;
        flush_pending_d = flush_pending_q | (bus.flush_i && state_q != IDLE);

        bus.req_ready_o   = 1'b0;
        bus.resp_valid_o  = 1'b0;
        bus.resp_hit_o    = 1'b0;
        bus.resp_way_o    = '0;
        bus.flush_done_o  = flush_done_q;
        bus.tag_req_o     = '0;
        bus.tag_we_o      = '0;
        bus.tag_addr_o    = '0;
        bus.tag_data_o    = '0;
        bus.tag_vbit_o    = 1'b0;
        bus.tag_flush_o   = 1'b0;
        bus.refill_req_o  = 1'b0;
        bus.refill_addr_o = '0;

        case (state_q)
            IDLE: begin
                bus.req_ready_o = !flush_pending_q && !bus.flush_i && !rst_i;
                if (flush_pending_q || bus.flush_i) begin
                    flush_pending_d = 1'b0;
                    state_d         = FLUSH;
                end else if (bus.req_valid_i) begin
                    addr_d  = bus.req_addr_i;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                bus.tag_req_o  = {WAYS{1'b1}};
                bus.tag_addr_o = addr_index(addr_q);
                state_d        = COMPARE;
            end
            COMPARE: begin
                if (hit_any) begin
                    resp_hit_d = 1'b1;
                    resp_way_d = hit_way;
                    state_d    = RESP;
                end else begin
                    victim_d   = victim;
                    from_ptr_d = victim_from_ptr;
                    state_d    = REFILL;
                end
            end
            REFILL: begin
                bus.refill_req_o  = 1'b1;
                bus.refill_addr_o = line_addr(addr_q);
                if (bus.refill_done_i) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                bus.tag_req_o  = victim_onehot;
                bus.tag_we_o   = victim_onehot;
                bus.tag_addr_o = addr_index(addr_q);
                bus.tag_data_o = addr_tag(addr_q);
                bus.tag_vbit_o = 1'b1;
                resp_hit_d     = 1'b0;
                resp_way_d     = victim_q;
                state_d        = RESP;
            end
            RESP: begin
                bus.resp_valid_o = 1'b1;
                bus.resp_hit_o   = resp_hit_q;
                bus.resp_way_o   = resp_way_q;
                state_d          = IDLE;
            end
            FLUSH: begin
                bus.tag_flush_o = 1'b1;
                flush_done_d    = 1'b1;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            victim_q        <= '0;
            from_ptr_q      <= 1'b0;
            resp_hit_q      <= 1'b0;
            resp_way_q      <= '0;
            flush_pending_q <= 1'b0;
            flush_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            victim_q        <= victim_d;
            from_ptr_q      <= from_ptr_d;
            resp_hit_q      <= resp_hit_d;
            resp_way_q      <= resp_way_d;
            flush_pending_q <= flush_pending_d;
            flush_done_q    <= flush_done_d;
        end
    end

endmodule

// File: tb/tb_icache_tag_lookup_ctrl.sv
// Directed bench for icache_tag_lookup_ctrl with a registered-read tag memory model.
module tb_icache_tag_lookup_ctrl;
    import drac_icache_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icache_tag_lookup_ctrl_if bus ();

    icache_tag_lookup_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    tag_t            mem_tag [WAYS][ICACHE_DEPTH];
    logic            mem_v   [WAYS][ICACHE_DEPTH];
    tag_t            rd_tag  [WAYS];
    logic [WAYS-1:0] rd_v;

    logic   poke_en;
    logic   poke_clear;
    int     poke_way;
    index_t poke_idx;
    tag_t   poke_tag;
    logic   poke_v;

    // Tag memory: one-cycle read latency, writes and flush take effect at the edge.
    always @(posedge clk) begin
        if (poke_clear || bus.tag_flush_o) begin
            for (int w = 0; w < WAYS; w++)
                for (int i = 0; i < ICACHE_DEPTH; i++)
                    mem_v[w][i] <= 1'b0;
        end
        if (poke_clear) rd_v <= '0;
        if (poke_en) begin
            mem_tag[poke_way][poke_idx] <= poke_tag;
            mem_v[poke_way][poke_idx]   <= poke_v;
        end
        for (int w = 0; w < WAYS; w++) begin
            if (bus.tag_req_o[w]) begin
                if (bus.tag_we_o[w]) begin
                    mem_tag[w][bus.tag_addr_o] <= bus.tag_data_o;
                    mem_v[w][bus.tag_addr_o]   <= bus.tag_vbit_o;
                end else begin
                    rd_tag[w] <= mem_tag[w][bus.tag_addr_o];
                    rd_v[w]   <= mem_v[w][bus.tag_addr_o];
                end
            end
        end
    end

    always_comb begin
        bus.tag_data_i = '0;
        for (int w = 0; w < WAYS; w++)
            bus.tag_data_i[w*TAG_WIDHT +: TAG_WIDHT] = rd_tag[w];
        bus.tag_vbit_i = rd_v;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic memPoke(input int way, input index_t idx, input tag_t tag, input logic v);
        poke_en  = 1'b1;
        poke_way = way;
        poke_idx = idx;
        poke_tag = tag;
        poke_v   = v;
        tick();
        poke_en  = 1'b0;
    endtask

    // Presents a request and returns at the negedge of the LOOKUP cycle.
    task automatic applyStimulus(input paddr_t addr);
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = addr;
        #1;
        for (int i = 0; i < 20 && bus.req_ready_o !== 1'b1; i++) tick();
        checkOutput("accept ready", 64'(bus.req_ready_o), 64'(1));
        tick();
        bus.req_valid_i = 1'b0;
    endtask

    task automatic waitRefill(input string name);
        for (int i = 0; i < 20 && bus.refill_req_o !== 1'b1; i++) tick();
        checkOutput({name, " refill_req rise"}, 64'(bus.refill_req_o), 64'(1));
    endtask

    task automatic serviceMiss(input paddr_t addr, input int delay, input int exp_way,
                               input string name);
        applyStimulus(addr);
        waitRefill(name);
        checkOutput({name, " refill_addr"}, 64'(bus.refill_addr_o), 64'({addr[31:4], 4'h0}));
        repeat (delay) tick();
        bus.refill_done_i = 1'b1;
        tick();
        bus.refill_done_i = 1'b0;
        checkOutput({name, " fill we"}, 64'(bus.tag_we_o), 64'(4'b0001 << exp_way));
        checkOutput({name, " fill tag"}, 64'(bus.tag_data_o), 64'(addr[31:12]));
        tick();
        checkOutput({name, " resp_valid"}, 64'(bus.resp_valid_o), 64'(1));
        checkOutput({name, " resp_hit"}, 64'(bus.resp_hit_o), 64'(0));
        checkOutput({name, " resp_way"}, 64'(bus.resp_way_o), 64'(exp_way));
        tick();
    endtask

    logic seen_we;
    logic seen_resp;

    initial begin
        rst               = 1'b1;
        bus.req_valid_i   = 1'b0;
        bus.req_addr_i    = '0;
        bus.flush_i       = 1'b0;
        bus.refill_done_i = 1'b0;
        poke_en           = 1'b0;
        poke_clear        = 1'b1;
        poke_way          = 0;
        poke_idx          = '0;
        poke_tag          = '0;
        poke_v            = 1'b0;
        tick();
        tick();
        poke_clear = 1'b0;

        $display("[TB] reset state");
        checkOutput("reset req_ready", 64'(bus.req_ready_o), 64'(0));
        checkOutput("reset resp_valid", 64'(bus.resp_valid_o), 64'(0));
        checkOutput("reset refill_req", 64'(bus.refill_req_o), 64'(0));
        checkOutput("reset tag_req", 64'(bus.tag_req_o), 64'(0));
        checkOutput("reset tag_flush", 64'(bus.tag_flush_o), 64'(0));
        checkOutput("reset flush_done", 64'(bus.flush_done_o), 64'(0));
        rst = 1'b0;
        tick();
        checkOutput("ready after reset", 64'(bus.req_ready_o), 64'(1));

        $display("[TB] cold miss");
        applyStimulus(32'h0001_2340);
        checkOutput("cold lookup tag_req", 64'(bus.tag_req_o), 64'(4'hF));
        checkOutput("cold lookup tag_we", 64'(bus.tag_we_o), 64'(0));
        checkOutput("cold lookup index", 64'(bus.tag_addr_o), 64'(8'h34));
        tick();
        checkOutput("cold compare refill_req", 64'(bus.refill_req_o), 64'(0));
        tick();
        checkOutput("cold refill_req cyc3", 64'(bus.refill_req_o), 64'(1));
        checkOutput("cold refill_addr", 64'(bus.refill_addr_o), 64'(32'h0001_2340));
        repeat (4) tick();
        checkOutput("cold refill held", 64'(bus.refill_req_o), 64'(1));
        tick();
        bus.refill_done_i = 1'b1;
        checkOutput("cold refill at done", 64'(bus.refill_req_o), 64'(1));
        tick();
        bus.refill_done_i = 1'b0;
        checkOutput("cold fill we", 64'(bus.tag_we_o), 64'(4'b0001));
        checkOutput("cold fill req", 64'(bus.tag_req_o), 64'(4'b0001));
        checkOutput("cold fill tag", 64'(bus.tag_data_o), 64'(20'h00012));
        checkOutput("cold fill index", 64'(bus.tag_addr_o), 64'(8'h34));
        checkOutput("cold fill vbit", 64'(bus.tag_vbit_o), 64'(1));
        checkOutput("cold fill refill_req", 64'(bus.refill_req_o), 64'(0));
        tick();
        checkOutput("cold resp_valid", 64'(bus.resp_valid_o), 64'(1));
        checkOutput("cold resp_hit", 64'(bus.resp_hit_o), 64'(0));
        checkOutput("cold resp_way", 64'(bus.resp_way_o), 64'(0));
        tick();
        checkOutput("cold resp pulse end", 64'(bus.resp_valid_o), 64'(0));

        $display("[TB] hit in way 2");
        memPoke(0, 8'h34, 20'h00012, 1'b0);
        memPoke(2, 8'h34, 20'h00012, 1'b1);
        applyStimulus(32'h0001_234C);
        checkOutput("hit no resp cyc1", 64'(bus.resp_valid_o), 64'(0));
        tick();
        checkOutput("hit no resp cyc2", 64'(bus.resp_valid_o), 64'(0));
        tick();
        checkOutput("hit resp_valid cyc3", 64'(bus.resp_valid_o), 64'(1));
        checkOutput("hit resp_hit", 64'(bus.resp_hit_o), 64'(1));
        checkOutput("hit resp_way", 64'(bus.resp_way_o), 64'(2));
        checkOutput("hit no refill", 64'(bus.refill_req_o), 64'(0));
        tick();
        checkOutput("hit ready cyc4", 64'(bus.req_ready_o), 64'(1));

        $display("[TB] round-robin victims");
        for (int w = 0; w < WAYS; w++) memPoke(w, 8'h55, 20'hAAA00 + tag_t'(w), 1'b1);
        for (int k = 0; k < 5; k++)
            serviceMiss({20'h00100 + tag_t'(k), 8'h55, 4'h0}, 1, k % WAYS,
                        $sformatf("rr miss %0d", k));

        $display("[TB] flush during refill");
        applyStimulus({20'h00200, 8'h55, 4'h0});
        waitRefill("flush-refill");
        tick();
        bus.flush_i = 1'b1;
        tick();
        bus.flush_i = 1'b0;
        checkOutput("refill survives flush", 64'(bus.refill_req_o), 64'(1));
        checkOutput("no early tag_flush", 64'(bus.tag_flush_o), 64'(0));
        bus.refill_done_i = 1'b1;
        tick();
        bus.refill_done_i = 1'b0;
        checkOutput("flush-refill fill we", 64'(bus.tag_we_o), 64'(4'b0010));
        tick();
        checkOutput("flush-refill resp_valid", 64'(bus.resp_valid_o), 64'(1));
        checkOutput("flush-refill resp_way", 64'(bus.resp_way_o), 64'(1));
        tick();
        checkOutput("pending idle tag_flush", 64'(bus.tag_flush_o), 64'(0));
        checkOutput("pending idle ready", 64'(bus.req_ready_o), 64'(0));
        tick();
        checkOutput("deferred tag_flush", 64'(bus.tag_flush_o), 64'(1));
        tick();
        checkOutput("deferred flush_done", 64'(bus.flush_done_o), 64'(1));
        checkOutput("tag_flush one cycle", 64'(bus.tag_flush_o), 64'(0));
        tick();
        checkOutput("flush_done one cycle", 64'(bus.flush_done_o), 64'(0));

        $display("[TB] pointer cleared by flush");
        for (int k = 0; k < WAYS; k++)
            serviceMiss({20'h00300 + tag_t'(k), 8'h66, 4'h0}, 0, k,
                        $sformatf("post-flush fill %0d", k));
        serviceMiss({20'h00304, 8'h66, 4'h0}, 0, 0, "post-flush pointer");

        $display("[TB] simultaneous flush and request");
        bus.flush_i     = 1'b1;
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 32'h0004_5670;
        #1;
        checkOutput("sim ready blocked", 64'(bus.req_ready_o), 64'(0));
        tick();
        bus.flush_i = 1'b0;
        #1;
        checkOutput("sim tag_flush", 64'(bus.tag_flush_o), 64'(1));
        checkOutput("sim ready in flush", 64'(bus.req_ready_o), 64'(0));
        tick();
        #1;
        checkOutput("sim flush_done", 64'(bus.flush_done_o), 64'(1));
        checkOutput("sim ready after flush", 64'(bus.req_ready_o), 64'(1));
        tick();
        bus.req_valid_i = 1'b0;
        checkOutput("sim lookup", 64'(bus.tag_req_o), 64'(4'hF));

        $display("[TB] reset during refill");
        waitRefill("reset-refill");
        rst = 1'b1;
        tick();
        checkOutput("reset drops refill_req", 64'(bus.refill_req_o), 64'(0));
        rst       = 1'b0;
        seen_we   = 1'b0;
        seen_resp = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.refill_done_i = (i == 2);
            tick();
            seen_we   = seen_we | (|bus.tag_we_o);
            seen_resp = seen_resp | bus.resp_valid_o;
        end
        bus.refill_done_i = 1'b0;
        checkOutput("no write after reset", 64'(seen_we), 64'(0));
        checkOutput("no resp after reset", 64'(seen_resp), 64'(0));
        checkOutput("ready after mid reset", 64'(bus.req_ready_o), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/icache_tag_lookup_ctrl.md
# icache_tag_lookup_ctrl

Instruction-cache tag controller: the requester that drives the per-way tag/valid-bit memories. It accepts core fetch addresses, reads all tag ways in parallel, compares the tags, and reports hit or miss. On a miss it requests a line refill from the next level, then writes the new tag and valid bit into a victim way. It also sequences whole-cache invalidation through the ways' flush input.

## Interface
- WAYS, 4: number of tag ways (power of two, ≥2)
- TAG_WIDTH, 20: tag bits per entry
- ADDR_WIDTH, 8: set-index bits (256 sets)
- OFFSET_WIDTH, 4: line-offset bits
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  fetch request valid
- req_ready_o  out  1  request accepted when valid & ready
- req_addr_i  in  TAG_WIDTH+ADDR_WIDTH+OFFSET_WIDTH  physical fetch address, split as {tag, index, offset}
- resp_valid_o  out  1  one-cycle response pulse
- resp_hit_o  out  1  1 = hit, 0 = serviced miss
- resp_way_o  out  clog2(WAYS)  way holding the line
- flush_i  in  1  invalidate-all request (pulse)
- flush_done_o  out  1  one-cycle pulse when invalidation is complete
- tag_req_o  out  WAYS  per-way memory request
- tag_we_o  out  WAYS  per-way write enable
- tag_addr_o  out  ADDR_WIDTH  set index to all ways
- tag_data_o  out  TAG_WIDTH  tag to write
- tag_vbit_o  out  1  valid bit to write
- tag_flush_o  out  1  clear all valid bits, broadcast to all ways
- tag_data_i  in  WAYS*TAG_WIDTH  read tags; way w is in bits [w*TAG_WIDTH +: TAG_WIDTH]
- tag_vbit_i  in  WAYS  read valid bits
- refill_req_o  out  1  line refill request, held high until done
- refill_addr_o  out  TAG_WIDTH+ADDR_WIDTH+OFFSET_WIDTH  line-aligned refill address (offset bits = 0)
- refill_done_i  in  1  refill complete (pulse)

## Operation
- States: IDLE, LOOKUP, COMPARE, REFILL, FILL, RESP, FLUSH.
- IDLE
  - req_ready_o = 1 only when no flush is pending and flush_i = 0.
  - On accept: latch address → LOOKUP.
  - A pending flush has priority over a new request → FLUSH.
- LOOKUP
  - tag_req_o = all ones, tag_we_o = 0, tag_addr_o = latched index → COMPARE.
- COMPARE (tag_data_i and tag_vbit_i are valid only in this cycle)
  - hit[w] = tag_vbit_i[w] & (tag[w] == latched tag).
  - Any hit: resp_hit_o = 1, resp_way_o = lowest-index hit way → RESP.
  - No hit: latch the victim → REFILL.
  - Victim = lowest-index way with vbit = 0; if all ways are valid, the round-robin pointer.
- REFILL
  - refill_req_o = 1, refill_addr_o = {tag, index, 0}.
  - On refill_done_i → FILL.
- FILL
  - One cycle: tag_req_o and tag_we_o one-hot on the victim, tag_data_o = latched tag, tag_vbit_o = 1.
  - The round-robin pointer increments (mod WAYS) only when the victim came from the pointer.
  - Then resp_hit_o = 0, resp_way_o = victim → RESP.
- RESP
  - resp_valid_o = 1 for one cycle → IDLE.
- FLUSH
  - tag_flush_o = 1 for one cycle; round-robin pointer cleared; flush_done_o = 1 in the following (IDLE) cycle.
- flush_i in any non-IDLE state sets flush_pending. The current operation (including an outstanding refill and its FILL) completes first; the flush then executes from IDLE.
- refill_done_i outside REFILL is ignored.

## Timing
- Reset:
  - All outputs are 0.
  - State = IDLE, flush_pending = 0, round-robin pointer = 0.
  - req_ready_o = 1 from the first cycle after reset deasserts.
- Hit latency (accept in cycle 0):
  - LOOKUP at 1, COMPARE at 2, resp_valid_o at 3.
  - Next accept possible at cycle 4.
- Miss latency (accept in cycle 0):
  - refill_req_o from cycle 3 through the cycle refill_done_i is seen (cycle N).
  - Write at N+1, resp_valid_o at N+2.
- Flush from IDLE (flush_i in cycle 0): FLUSH at 1, flush_done_o at 2. req_ready_o = 0 in cycles 0–1.
- Reset mid-refill: refill_req_o drops in the cycle after rst_i is sampled high. No tag write and no response occur.
- Simultaneous flush_i and req_valid_i in IDLE: the flush wins and the request is not accepted.

## Structure
- Shared package drac_icache_pkg holds:
  - TAG_WIDHT, ADDR_WIDHT, ICACHE_DEPTH, WAYS, OFFSET_WIDTH;
  - the state enum;
  - the address field-slice helpers.
- One sub-module: icache_victim_sel.
  - Contains the first-invalid priority encoder plus the round-robin pointer register.
  - Has advance and clear inputs; outputs the victim index and a from-pointer flag.

## Test plan
- Cold miss:
  - Stimulus: all ways invalid; request 0x0001_2340, refill_done_i 5 cycles after refill_req_o rises.
  - Response: refill_addr_o = 0x0001_2340; way 0 written with tag 0x00012, index 0x34, vbit 1; response hit = 0, way = 0.
- Hit:
  - Stimulus: way 2 returns tag 0x00012 with vbit 1 at index 0x34; request 0x0001_234C.
  - Response: resp_valid_o exactly 3 cycles after accept, hit = 1, way = 2; no refill_req_o.
- Round-robin victim:
  - Stimulus: all 4 ways valid with non-matching tags; five consecutive misses.
  - Response: victims are 0, 1, 2, 3, 0.
- Flush during refill:
  - Stimulus: flush_i pulsed while in REFILL.
  - Response: the fill still completes and responds; tag_flush_o pulses 1 cycle after return to IDLE; flush_done_o 1 cycle later; pointer reads 0.
- Reset mid-refill:
  - Stimulus: rst_i asserted during REFILL; refill_done_i arrives later.
  - Response: refill_req_o = 0 the next cycle; no tag_we_o; no resp_valid_o.
- Simultaneous flush and request:
  - Stimulus: flush_i and req_valid_i high together in IDLE.
  - Response: request not accepted; flush completes first; request accepted after flush_done_o.
